// File: rtl/gait_pkg.sv
// Shared types and width helpers for the gait scheduler and its round-robin picker.
package gait_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GAP   = 2'd2,
    ST_FAULT = 2'd3
  } gait_state_e;

  localparam int N_LEGS_DEF  = 8;
  localparam int TIMEOUT_DEF = 1024;

  localparam int LEG_IDX_W = $clog2(N_LEGS_DEF);
  localparam int CNT_W     = $clog2(N_LEGS_DEF + 1);
  localparam int TMR_W     = $clog2(TIMEOUT_DEF);

endpackage

// File: rtl/gait_rr_picker.sv
// Combinational round-robin picker: lowest eligible index at or after ptr_i, wrapping.
module gait_rr_picker #(
  parameter int N = gait_pkg::N_LEGS_DEF,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] eligible_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] grant_o
);

  logic [2*N-1:0] dbl;

  // The upper copy of the vector supplies the wrapped candidates below the pointer.
  always_comb begin
    dbl     = {eligible_i, eligible_i};
    valid_o = 1'b0;
    grant_o = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl[j] && (j >= int'(ptr_i))) begin
        valid_o = 1'b1;
        grant_o = (j >= N) ? W'(j - N) : W'(j);
      end
    end
  end

endmodule

// File: rtl/gait_scheduler.sv
// Step scheduler: grants leg step starts under concurrency, adjacency and spacing limits,
// tracks stepping legs, and latches a fault when a leg stays active too long.
module gait_scheduler
  import gait_pkg::*;
#(
  parameter int N_LEGS     = 8,
  parameter int MAX_ACTIVE = 2,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 1024,
  parameter int IDX_W      = $clog2(N_LEGS),
  parameter int CW         = $clog2(N_LEGS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_LEGS-1:0] leg_req,
  input  logic [N_LEGS-1:0] leg_done,
  input  logic              err_clr,
  output logic [N_LEGS-1:0] leg_start,
  output logic [N_LEGS-1:0] leg_active,
  output logic [CW-1:0]     active_cnt,
  output logic              busy,
  output logic              fault,
  output logic [IDX_W-1:0]  err_leg
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  gait_state_e       state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [N_LEGS-1:0] leg_start_q, leg_start_d;
  logic [N_LEGS-1:0] leg_active_q, leg_active_d;
  logic [CW-1:0]     active_cnt_q, active_cnt_d;
  logic              busy_q;
  logic              fault_q, fault_d;
  logic [IDX_W-1:0]  err_leg_q, err_leg_d;

  logic [N_LEGS-1:0] done_hit;
  logic [N_LEGS-1:0] eligible;
  logic [N_LEGS-1:0] expire;
  logic              expire_any;
  logic [IDX_W-1:0]  expire_idx;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              clr_all;

  assign done_hit = leg_done & leg_active_q;
  assign clr_all  = (state_q == ST_FAULT) && err_clr;
  assign eligible = leg_req & ~leg_active_q
                  & ~{leg_active_q[N_LEGS-2:0], leg_active_q[N_LEGS-1]}
                  & ~{leg_active_q[0], leg_active_q[N_LEGS-1:1]};

  gait_rr_picker #(
    .N (N_LEGS),
    .W (IDX_W)
  ) u_picker (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .valid_o    (pick_valid),
    .grant_o    (pick_idx)
  );

  // Per-leg step timers; a timer parks at TIMEOUT-1 so the expiry stays visible in FAULT.
  for (genvar gi = 0; gi < N_LEGS; gi++) begin : g_tmr
    logic [TW-1:0] tmr_q, tmr_d;

    assign expire[gi] = leg_active_q[gi] && (tmr_q == TW'(TIMEOUT - 1));

    always_comb begin
      tmr_d = tmr_q;
      if (clr_all || done_hit[gi]) begin
        tmr_d = '0;
      end else if ((state_q != ST_FAULT) && leg_active_q[gi] && !expire[gi]) begin
        tmr_d = tmr_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) tmr_q <= '0;
      else      tmr_q <= tmr_d;
    end
  end

  always_comb begin
    expire_any = 1'b0;
    expire_idx = '0;
    for (int i = N_LEGS-1; i >= 0; i--) begin
      if (expire[i]) begin
        expire_any = 1'b1;
        expire_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gap_d        = gap_q;
    leg_start_d  = '0;
    leg_active_d = leg_active_q & ~done_hit;
    fault_d      = fault_q;
    err_leg_d    = err_leg_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if ((int'(active_cnt_q) < MAX_ACTIVE) && pick_valid && !expire_any) begin
          leg_start_d[pick_idx]  = 1'b1;
          leg_active_d[pick_idx] = 1'b1;
          ptr_d   = (pick_idx == IDX_W'(N_LEGS - 1)) ? '0 : pick_idx + 1'b1;
          gap_d   = GW'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = enable ? ST_ARB : ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      ST_FAULT: begin
        if (err_clr) begin
          leg_active_d = '0;
          fault_d      = 1'b0;
          err_leg_d    = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A timeout wins over every other transition; a same-cycle done still clears its leg.
    if ((state_q != ST_FAULT) && expire_any) begin
      state_d   = ST_FAULT;
      fault_d   = 1'b1;
      err_leg_d = expire_idx;
    end
  end

  always_comb begin
    active_cnt_d = '0;
    for (int i = 0; i < N_LEGS; i++) begin
      active_cnt_d = active_cnt_d + CW'(leg_active_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gap_q        <= '0;
      leg_start_q  <= '0;
      leg_active_q <= '0;
      active_cnt_q <= '0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      err_leg_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gap_q        <= gap_d;
      leg_start_q  <= leg_start_d;
      leg_active_q <= leg_active_d;
      active_cnt_q <= active_cnt_d;
      busy_q       <= |leg_active_d;
      fault_q      <= fault_d;
      err_leg_q    <= err_leg_d;
    end
  end

  assign leg_start  = leg_start_q;
  assign leg_active = leg_active_q;
  assign active_cnt = active_cnt_q;
  assign busy       = busy_q;
  assign fault      = fault_q;
  assign err_leg    = err_leg_q;

endmodule

// File: tb/tb_gait_scheduler.sv
// Directed bench for gait_scheduler: arbitration order, spacing, adjacency, wrap, timeout, reset.
module tb_gait_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] leg_req;
  logic [7:0] leg_done;
  logic       err_clr;
  logic [7:0] leg_start;
  logic [7:0] leg_active;
  logic [3:0] active_cnt;
  logic       busy;
  logic       fault;
  logic [2:0] err_leg;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  gait_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .leg_req    (leg_req),
    .leg_done   (leg_done),
    .err_clr    (err_clr),
    .leg_start  (leg_start),
    .leg_active (leg_active),
    .active_cnt (active_cnt),
    .busy       (busy),
    .fault      (fault),
    .err_leg    (err_leg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] done;
    logic       clr;
    logic [7:0] exp_act;
    logic [3:0] exp_cnt;
    logic       exp_busy;
  } row_t;

  row_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int budget, output int idx, output int at, output bit got);
    got = 1'b0;
    idx = -1;
    at  = 0;
    for (int k = 0; k < budget && !got; k++) begin
      step();
      if (leg_start != 8'h00) begin
        got = 1'b1;
        at  = cyc;
        for (int i = 0; i < 8; i++) if (leg_start[i]) idx = i;
        chk("start_onehot", 32'($onehot(leg_start)), 32'd1);
        $display("start leg %0d at cycle %0d", idx, at);
      end
    end
  endtask

  task automatic pulse_done(input logic [7:0] d);
    leg_done = d;
    step();
    leg_done = 8'h00;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_start"},  32'(leg_start),  32'h0);
    chk({tag, "_active"}, 32'(leg_active), 32'h0);
    chk({tag, "_cnt"},    32'(active_cnt), 32'h0);
    chk({tag, "_busy"},   32'(busy),       32'h0);
    chk({tag, "_fault"},  32'(fault),      32'h0);
    chk({tag, "_errleg"}, 32'(err_leg),    32'h0);
  endtask

  int idx, t0, t1, tf;
  bit got;

  initial begin
    tbl[0] = '{done: 8'h00, clr: 1'b0, exp_act: 8'h05, exp_cnt: 4'd2, exp_busy: 1'b1};
    tbl[1] = '{done: 8'h02, clr: 1'b0, exp_act: 8'h05, exp_cnt: 4'd2, exp_busy: 1'b1};
    tbl[2] = '{done: 8'h00, clr: 1'b1, exp_act: 8'h05, exp_cnt: 4'd2, exp_busy: 1'b1};
    tbl[3] = '{done: 8'h05, clr: 1'b0, exp_act: 8'h00, exp_cnt: 4'd0, exp_busy: 1'b0};
    tbl[4] = '{done: 8'h00, clr: 1'b0, exp_act: 8'h00, exp_cnt: 4'd0, exp_busy: 1'b0};
    tbl[5] = '{done: 8'hFF, clr: 1'b0, exp_act: 8'h00, exp_cnt: 4'd0, exp_busy: 1'b0};

    rst = 1'b0; enable = 1'b0; leg_req = 8'h00; leg_done = 8'h00; err_clr = 1'b0;
    #12;
    check_idle_outputs("reset");
    step();
    rst = 1'b1;

    // Arbitration order and spacing
    enable = 1'b1; leg_req = 8'hFF;
    wait_start(10, idx, t0, got);
    chk("arb_first_got", 32'(got), 32'd1);
    chk("arb_first_leg", 32'(idx), 32'd0);
    chk("arb_first_active", 32'(leg_active), 32'h01);
    chk("arb_first_cnt", 32'(active_cnt), 32'd1);
    wait_start(40, idx, t1, got);
    chk("arb_second_leg", 32'(idx), 32'd2);
    chk("arb_spacing", 32'(t1 - t0), 32'd17);
    chk("arb_second_active", 32'(leg_active), 32'h05);
    chk("arb_second_cnt", 32'(active_cnt), 32'd2);
    wait_start(40, idx, t1, got);
    chk("cap_no_start", 32'(got), 32'd0);

    // Release and round-robin
    pulse_done(8'h01);
    chk("release_active", 32'(leg_active), 32'h04);
    wait_start(3, idx, t1, got);
    chk("rr_leg", 32'(idx), 32'd4);
    chk("rr_active", 32'(leg_active), 32'h14);

    leg_req = 8'h00;
    pulse_done(8'h14);
    chk("multi_done_active", 32'(leg_active), 32'h00);

    // Adjacency block
    leg_req = 8'h03;
    wait_start(40, idx, t1, got);
    chk("adj_first_leg", 32'(idx), 32'd0);
    wait_start(40, idx, t1, got);
    chk("adj_blocked", 32'(got), 32'd0);
    leg_done = 8'h01;
    wait_start(2, idx, t1, got);
    leg_done = 8'h00;
    chk("adj_unblock_got", 32'(got), 32'd1);
    chk("adj_unblock_leg", 32'(idx), 32'd1);

    // Walk the pointer to 7 via a lone grant on leg 6
    leg_req = 8'h00;
    pulse_done(8'h02);
    leg_req = 8'h40;
    wait_start(40, idx, t1, got);
    chk("ptr_walk_leg", 32'(idx), 32'd6);
    leg_req = 8'h00;
    step();
    chk("req_drop_keeps_active", 32'(leg_active), 32'h40);
    pulse_done(8'h40);

    // Wrap-around
    leg_req = 8'h81;
    wait_start(40, idx, t1, got);
    chk("wrap_leg", 32'(idx), 32'd7);
    wait_start(40, idx, t1, got);
    chk("wrap_adj_blocked", 32'(got), 32'd0);
    chk("wrap_active", 32'(leg_active), 32'h80);

    // Timeout
    leg_req = 8'h00;
    pulse_done(8'h80);
    leg_req = 8'h08;
    wait_start(40, idx, t0, got);
    chk("tmo_leg", 32'(idx), 32'd3);
    leg_req = 8'h00;
    got = 1'b0;
    tf = 0;
    for (int k = 0; k < 1100 && !got; k++) begin
      step();
      if (fault) begin got = 1'b1; tf = cyc; end
    end
    chk("tmo_fault_seen", 32'(got), 32'd1);
    chk("tmo_latency", 32'(tf - t0), 32'd1024);
    chk("tmo_err_leg", 32'(err_leg), 32'd3);
    chk("tmo_active_held", 32'(leg_active), 32'h08);
    leg_req = 8'hFF;
    wait_start(30, idx, t1, got);
    chk("fault_no_start", 32'(got), 32'd0);
    chk("fault_sticky", 32'(fault), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_idle_outputs("errclr");
    wait_start(10, idx, t1, got);
    chk("restart_leg", 32'(idx), 32'd4);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("errclr_ignored", 32'(leg_active), 32'h10);

    // Async reset mid-step
    wait_start(40, idx, t1, got);
    chk("pre_reset_leg", 32'(idx), 32'd6);
    chk("pre_reset_active", 32'(leg_active), 32'h50);
    step(); step(); step();
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    step();
    rst = 1'b1;
    wait_start(10, idx, t1, got);
    chk("post_reset_leg", 32'(idx), 32'd0);
    wait_start(40, idx, t1, got);
    chk("post_reset_second", 32'(idx), 32'd2);

    // Completion table with new starts disabled
    enable = 1'b0; leg_req = 8'h00;
    for (int r = 0; r < 6; r++) begin
      leg_done = tbl[r].done;
      err_clr  = tbl[r].clr;
      step();
      leg_done = 8'h00;
      err_clr  = 1'b0;
      chk($sformatf("tbl%0d_active", r), 32'(leg_active), 32'(tbl[r].exp_act));
      chk($sformatf("tbl%0d_cnt", r),    32'(active_cnt), 32'(tbl[r].exp_cnt));
      chk($sformatf("tbl%0d_busy", r),   32'(busy),       32'(tbl[r].exp_busy));
      chk($sformatf("tbl%0d_start", r),  32'(leg_start),  32'h0);
      chk($sformatf("tbl%0d_fault", r),  32'(fault),      32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gait_scheduler.md
Name: gait_scheduler

Overview:
- Sequences the per-leg three-phase step controllers (start -> lifted -> planted).
- Decides which leg may begin a step and when, so the body stays supported:
  - caps the number of concurrently stepping legs;
  - forbids ring-adjacent legs stepping together;
  - enforces a minimum spacing between step starts.
- Sits between the gait/behaviour layer (leg_req) and the leg controllers (leg_start pulse drives each controller's start input; its planted indication returns as leg_done).

Parameters:
- N_LEGS, 8: number of legs. Legs form a ring; leg i neighbours are (i±1) mod N_LEGS.
- MAX_ACTIVE, 2: maximum legs stepping at once. Legal range 1..N_LEGS/2.
- GAP_CYCLES, 16: minimum clk cycles from one leg_start pulse to the next. Must be ≥1.
- TIMEOUT, 1024: cycles an active leg may remain active before a fault.

Ports:
- clk, in, 1: system clock; all logic is on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- enable, in, 1: permits new step starts.
- leg_req, in, N_LEGS: level signal per leg; leg wants to step.
- leg_done, in, N_LEGS: single-cycle pulse per leg; the leg has planted.
- err_clr, in, 1: single-cycle pulse; leaves FAULT.
- leg_start, out, N_LEGS: one-hot-or-zero single-cycle start pulse.
- leg_active, out, N_LEGS: bitmap of legs currently stepping.
- active_cnt, out, clog2(N_LEGS+1): population count of leg_active (registered).
- busy, out, 1: OR-reduction of leg_active.
- fault, out, 1: sticky timeout flag.
- err_leg, out, clog2(N_LEGS): index of the timed-out leg.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0;
  - FSM = IDLE;
  - round-robin pointer = 0;
  - gap counter and all per-leg timers = 0.
- FSM states: IDLE, ARB, GAP, FAULT.
- IDLE: enable=1 -> ARB next cycle.
- ARB eligibility and grant:
  - eligible = leg_req & ~leg_active & ~rotl(leg_active,1) & ~rotr(leg_active,1).
  - If enable=0 -> IDLE.
  - Else if active_cnt < MAX_ACTIVE and eligible != 0: grant g = first eligible index at or after the pointer, searching upward with wrap.
  - On grant:
    - next cycle leg_start[g]=1 for exactly one cycle;
    - leg_active[g]=1 in that same cycle;
    - pointer <= (g+1) mod N_LEGS;
    - gap counter <= GAP_CYCLES-1;
    - FSM -> GAP.
  - Otherwise remain in ARB.
- GAP: gap counter decrements each cycle. At 0 -> ARB, or IDLE if enable=0. Result: consecutive leg_start pulses are at least GAP_CYCLES+1 cycles apart.
- Completion:
  - leg_done[i]=1 with leg_active[i]=1 clears leg_active[i] the next cycle and resets timer i.
  - leg_done on an inactive leg is ignored.
  - Done on several legs in the same cycle clears all of them.
- Same-cycle completion and arbitration: arbitration in a cycle uses leg_active as registered at that cycle's start. A leg freed by leg_done becomes eligible, and its neighbours unblocked, one cycle later.
- Timers:
  - timer i counts while leg_active[i]=1.
  - On reaching TIMEOUT-1 on any leg, the next cycle:
    - fault=1;
    - err_leg = lowest such index;
    - FSM -> FAULT.
  - Done arriving in the same cycle as expiry still clears the leg, but the fault still fires.
- FAULT:
  - no leg_start is issued;
  - leg_done continues to clear legs;
  - timers freeze.
  - err_clr -> leg_active cleared, timers cleared, fault=0, err_leg=0, FSM -> IDLE.
  - err_clr outside FAULT is ignored.
- Dropping enable: never aborts legs already stepping; only new starts stop.
- leg_req dropped after grant: has no effect on the active leg.
- Output derivation: active_cnt and busy are registered from next-state leg_active, so they agree with leg_active in every cycle.

Decomposition:
- Shared package gait_pkg:
  - FSM state encoding (IDLE=0, ARB=1, GAP=2, FAULT=3);
  - width helper constants LEG_IDX_W and CNT_W;
  - timer width TMR_W = clog2(TIMEOUT).
- One sub-module, gait_rr_picker (combinational):
  - inputs: eligible vector and pointer;
  - outputs: grant-valid and grant index;
  - implementation: double-width priority search.

Test Plan:
- Reset and arbitration order:
  - Stimulus: reset; enable=1; leg_req=8'hFF; no leg_done.
  - Required response: starts on leg 0, then leg 2 (leg 1 is adjacent to leg 0). Then no further start, since active_cnt=2=MAX_ACTIVE. Starts are 17 cycles apart.
- Release and round-robin:
  - Stimulus: from the previous state, pulse leg_done[0].
  - Required response: leg_active[0] clears next cycle. The next start goes to leg 4: the pointer is at 3, and leg 3 is adjacent to leg 2.
- Adjacency block:
  - Stimulus: leg_req=8'b0000_0011.
  - Required response: leg 0 starts. leg 1 never starts until leg_done[0] arrives; it starts within ≤2 cycles of that (gap already elapsed).
- Wrap-around:
  - Stimulus: pointer at 7; leg_req=8'b1000_0001; leg 0 and leg 7 inactive.
  - Required response: leg 7 granted first; leg 0 is then blocked as adjacent.
- Timeout:
  - Stimulus: leg 3 active; no done for 1024 cycles.
  - Required response: fault=1 and err_leg=3; no starts while in FAULT. After err_clr: leg_active=0 and fault=0, then restart from IDLE.
- Async reset mid-step:
  - Stimulus: drive rst low between clock edges while two legs are active in GAP.
  - Required response: all outputs go to 0 immediately, without waiting for a clock edge. After release the first grant uses pointer 0.
